// File: rtl/alu_seq_if.sv
// Operation handshake between a requester and alu_seq: start/op/operands in,
// registered result, flags, busy and done out.
interface alu_seq_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  alu_start;
    logic [2:0]            alu_op;
    logic [DATA_WIDTH-1:0] operand_a_in;
    logic [DATA_WIDTH-1:0] operand_b_in;
    logic [DATA_WIDTH-1:0] alu_result_out;
    logic                  zero_indicator_out;
    logic                  signal_bit_out;
    logic                  alu_busy;
    logic                  alu_done;

    modport master (
        output alu_start, alu_op, operand_a_in, operand_b_in,
        input  alu_result_out, zero_indicator_out, signal_bit_out, alu_busy, alu_done
    );

    modport slave (
        input  alu_start, alu_op, operand_a_in, operand_b_in,
        output alu_result_out, zero_indicator_out, signal_bit_out, alu_busy, alu_done
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops, optional shift-add multiplier.
// Define ALU_MUL_EN to build the MUL state for op 111; otherwise op 111 returns 0.
module alu_seq #(
    parameter int DATA_WIDTH = 16
) (
    input  logic       clock,
    input  logic       alu_reset,
    alu_seq_if.slave   bus
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    typedef logic [DATA_WIDTH-1:0] word_t;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
`else
    typedef enum logic [0:0] {IDLE, EXEC} state_t;
`endif

    state_t      state_q, state_d;
    logic        accept, finish;
    word_t       result_d;
    logic [2:0]  op_p0;
    word_t       a_p0, b_p0;

`ifdef ALU_MUL_EN
    word_t           acc_p0;
    logic [SH_W-1:0] cnt;
`endif

    function automatic word_t alu_eval(input logic [2:0] op, input word_t a, input word_t b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~a;
            3'b110:  return a << b[SH_W-1:0];
            default: return '0;
        endcase
    endfunction

    function automatic word_t mul_step(input word_t acc, input word_t mcand, input logic mbit);
        return mbit ? acc + mcand : acc;
    endfunction

    always_ff @(posedge clock or posedge alu_reset) begin
        if (alu_reset) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        finish   = 1'b0;
        result_d = alu_eval(op_p0, a_p0, b_p0);
        case (state_q)
            IDLE: begin
                if (bus.alu_start) begin
                    accept  = 1'b1;
                    state_d = EXEC;
`ifdef ALU_MUL_EN
                    if (bus.alu_op == 3'b111) state_d = MUL;
`endif
                end
            end
            EXEC: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
`ifdef ALU_MUL_EN
            // Last iteration folds its partial product straight into the result.
            MUL: begin
                if (cnt == '0) begin
                    finish   = 1'b1;
                    state_d  = IDLE;
                    result_d = mul_step(acc_p0, a_p0, b_p0[0]);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.alu_busy = (state_q != IDLE);

    // Operand latch; during MUL A shifts left as multiplicand, B right as multiplier.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_p0 <= bus.alu_op;
            a_p0  <= bus.operand_a_in;
            b_p0  <= bus.operand_b_in;
`ifdef ALU_MUL_EN
            acc_p0 <= '0;
`endif
        end
`ifdef ALU_MUL_EN
        else if (state_q == MUL) begin
            acc_p0 <= mul_step(acc_p0, a_p0, b_p0[0]);
            a_p0   <= a_p0 << 1;
            b_p0   <= b_p0 >> 1;
        end
`endif
    end

    always_ff @(posedge clock or posedge alu_reset) begin
        if (alu_reset) begin
            bus.alu_result_out     <= '0;
            bus.zero_indicator_out <= 1'b0;
            bus.signal_bit_out     <= 1'b0;
            bus.alu_done           <= 1'b0;
`ifdef ALU_MUL_EN
            cnt                    <= '0;
`endif
        end else begin
            bus.alu_done <= finish;
            if (finish) begin
                bus.alu_result_out     <= result_d;
                bus.zero_indicator_out <= (result_d == '0);
                bus.signal_bit_out     <= result_d[DATA_WIDTH-1];
            end
`ifdef ALU_MUL_EN
            if (accept)
                cnt <= SH_W'(DATA_WIDTH - 1);
            else if (state_q == MUL && cnt != '0)
                cnt <= cnt - 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (DATA_WIDTH=16); adapts to ALU_MUL_EN being defined or not.
module tb_alu_seq;
    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam int MUL_LAT = W;
`else
    localparam int MUL_LAT = 1;
`endif

    logic clock = 1'b0;
    logic alu_reset;

    alu_seq_if #(.DATA_WIDTH(W)) bus();

    alu_seq #(.DATA_WIDTH(W)) dut (
        .clock     (clock),
        .alu_reset (alu_reset),
        .bus       (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         n;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] last_res;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = a * b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << b[3:0];
`ifdef ALU_MUL_EN
            default: return prod[W-1:0];
`else
            default: return '0;
`endif
        endcase
    endfunction

    function automatic void push_exp(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        exp_t e;
        e.res = model(op, a, b);
        e.z   = (e.res == '0);
        e.n   = e.res[W-1];
        exp_q.push_back(e);
        last_res = e.res;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (alu_reset === 1'b0 && bus.alu_done === 1'b1) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("unexpected_done", bus.alu_done, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("result", bus.alu_result_out, e.res);
                check("zero_flag", bus.zero_indicator_out, e.z);
                check("sign_flag", bus.signal_bit_out, e.n);
            end
        end
    end

    task automatic drive_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.alu_op       = op;
        bus.operand_a_in = a;
        bus.operand_b_in = b;
        bus.alu_start    = 1'b1;
        @(posedge clock);
        #1;
        bus.alu_start    = 1'b0;
        bus.alu_op       = 3'($urandom);
        bus.operand_a_in = W'($urandom);
        bus.operand_b_in = W'($urandom);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input bit check_hold);
        int lat  = 0;
        int busy = 0;
        do begin
            @(negedge clock);
            lat++;
            if (bus.alu_busy === 1'b1) busy++;
        end while (bus.alu_done !== 1'b1 && lat < 200);
        check({tag, "_latency"}, lat - 1, exp_lat);
        check({tag, "_busy_cycles"}, busy, exp_lat);
        if (check_hold) begin
            @(negedge clock);
            check({tag, "_done_pulse"}, bus.alu_done, 1'b0);
            check({tag, "_hold"}, bus.alu_result_out, last_res);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        push_exp(op, a, b);
        drive_start(op, a, b);
        wait_done(tag, (op == 3'b111) ? MUL_LAT : 1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.alu_start    = 1'b0;
        bus.alu_op       = 3'd0;
        bus.operand_a_in = '0;
        bus.operand_b_in = '0;
        alu_reset        = 1'b0;
        #2 alu_reset = 1'b1;
        #1;
        check("rst_result", bus.alu_result_out, 16'h0000);
        check("rst_zero", bus.zero_indicator_out, 1'b0);
        check("rst_sign", bus.signal_bit_out, 1'b0);
        check("rst_busy", bus.alu_busy, 1'b0);
        check("rst_done", bus.alu_done, 1'b0);
        @(negedge clock);
        @(negedge clock);
        alu_reset = 1'b0;

        run_op(3'd0, 16'h0003, 16'hFFFD, "add_wrap");
        run_op(3'd1, 16'h0002, 16'h0005, "sub_neg");

`ifdef ALU_MUL_EN
        run_op(3'd7, 16'h0012, 16'h0034, "mul");

        push_exp(3'd7, 16'h0012, 16'h0034);
        drive_start(3'd7, 16'h0012, 16'h0034);
        repeat (4) @(negedge clock);
        bus.alu_op       = 3'd0;
        bus.operand_a_in = 16'h1234;
        bus.operand_b_in = 16'h4321;
        bus.alu_start    = 1'b1;
        @(posedge clock);
        #1 bus.alu_start = 1'b0;
        wait_done("mul_ignore_start", MUL_LAT - 4, 1'b0);
        push_exp(3'd0, 16'h7FFF, 16'h0001);
        drive_start(3'd0, 16'h7FFF, 16'h0001);
        wait_done("b2b_add", 1, 1'b1);

        drive_start(3'd7, 16'h00AB, 16'h0101);
        repeat (8) @(negedge clock);
`else
        run_op(3'd7, 16'h0003, 16'h0004, "op7_no_mul");
        run_op(3'd0, 16'h7FFF, 16'h0001, "add_ovf");

        drive_start(3'd6, 16'h0001, 16'h0003);
`endif
        #1 alu_reset = 1'b1;
        #1;
        check("abort_result", bus.alu_result_out, 16'h0000);
        check("abort_zero", bus.zero_indicator_out, 1'b0);
        check("abort_sign", bus.signal_bit_out, 1'b0);
        check("abort_busy", bus.alu_busy, 1'b0);
        check("abort_done", bus.alu_done, 1'b0);
        @(negedge clock);
        @(negedge clock);
        alu_reset = 1'b0;
        run_op(3'd2, 16'h00F0, 16'h0F0F, "and_after_abort");

        run_op(3'd3, 16'h1200, 16'h0034, "or");
        run_op(3'd4, 16'hFFFF, 16'h8000, "xor");
        run_op(3'd5, 16'hFFFF, 16'h1234, "not_zero");
        run_op(3'd6, 16'h0001, 16'h00FF, "sll_max");
        for (int i = 0; i < 10; i++) begin
            run_op(3'($urandom), W'($urandom), W'($urandom), "random");
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the operand/result width (minimum 4).
REQ-002 The block SHALL have port clock  input  1  the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port alu_reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port alu_start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port alu_op  input  3  operation select; encodings are listed in REQ-012.
REQ-006 The block SHALL have ports operand_a_in and operand_b_in  input  DATA_WIDTH  operands, latched when alu_start is accepted.
REQ-007 The block SHALL have port alu_result_out  output  DATA_WIDTH  registered result.
REQ-008 The block SHALL have ports zero_indicator_out and signal_bit_out  output  1  registered flags that feed the status register's zero_indicator_in and signal_bit_in.
REQ-009 The block SHALL have port alu_busy  output  1  high whenever the state is not IDLE.
REQ-010 The block SHALL have port alu_done  output  1  registered one-cycle pulse marking completion; it drives status_wr.

Function
REQ-011 The state machine SHALL have states IDLE, EXEC and MUL.
  - IDLE with alu_start=1 at edge N: latch alu_op and both operands.
  - Go to MUL if alu_op=111 and ALU_MUL_EN is defined; otherwise go to EXEC.
REQ-012 The operation encodings SHALL be:
  - 000 ADD; 001 SUB (A-B); 010 AND; 011 OR; 100 XOR; 101 NOT A.
  - 110 SLL: A shifted left by the low $clog2(DATA_WIDTH) bits of B.
  - 111 MUL.
REQ-013 ADD, SUB and MUL SHALL wrap modulo 2^DATA_WIDTH and discard carry, borrow and high product bits.
REQ-014 EXEC SHALL complete in one cycle.
  - At edge N+1: register the result and flags, set alu_done=1, return to IDLE.
REQ-015 MUL SHALL be an unsigned shift-add over DATA_WIDTH iterations.
  - A down-counter is loaded with DATA_WIDTH-1 at acceptance.
  - At edge N+DATA_WIDTH: register the low half of the product and the flags, set alu_done=1, return to IDLE.
REQ-016 The flags SHALL be updated only on completion.
  - zero_indicator_out = (result == 0).
  - signal_bit_out = result[DATA_WIDTH-1].
  - Both update in the same edge as alu_result_out.
REQ-017 Between completions, alu_result_out and both flags SHALL hold their last values.
REQ-018 alu_done SHALL be high for exactly one cycle per accepted operation and low otherwise.
REQ-019 alu_start SHALL be ignored while alu_busy=1.
  - No re-latching of operands.
  - No change to the operation in progress.
REQ-020 Back-to-back operation: alu_start in the cycle where alu_done=1 SHALL be accepted, since the state is already IDLE.
REQ-021 Changes to operand_a_in, operand_b_in or alu_op after acceptance SHALL NOT affect the running operation.

Reset
REQ-022 Asserting alu_reset SHALL immediately, without waiting for a clock edge:
  - set the state to IDLE and the counter to 0;
  - set alu_result_out=0, zero_indicator_out=0, signal_bit_out=0, alu_busy=0, alu_done=0.
REQ-023 A reset during EXEC or MUL SHALL abort the operation with no alu_done pulse.
REQ-024 The block SHALL accept alu_start on the first rising edge after alu_reset deasserts.

Configuration
REQ-025 Macro ALU_MUL_EN SHALL control the multiplier.
  - Defined: op 111 runs the MUL path per REQ-015.
  - Undefined: no MUL state or counter is built; op 111 takes the EXEC path with result 0, so zero_indicator_out=1 and signal_bit_out=0.

Verification (DATA_WIDTH=16, ALU_MUL_EN defined unless stated)
REQ-026 The bench SHALL cover these directed scenarios:
  - Reset, then ADD 0x0003+0xFFFD at edge N -> at N+1: alu_done=1 for one cycle, result 0x0000, Z=1, N=0.
  - SUB 0x0002-0x0005 -> result 0xFFFD, Z=0, N=1; alu_busy high for exactly one cycle.
  - MUL 0x0012*0x0034 -> alu_busy high for 16 cycles, alu_done at N+16, result 0x03A8, Z=0, N=0.
  - Pulse ADD alu_start during MUL cycle 5 with new operands -> ignored; the single alu_done reports MUL result 0x03A8. Then start ADD 0x7FFF+0x0001 in the alu_done cycle -> result 0x8000, N=1 one cycle later.
  - Assert alu_reset asynchronously mid-MUL (cycle 8) -> all outputs 0 before the next edge and no alu_done. After release, AND 0x00F0&0x0F0F -> result 0x0000, Z=1.
  - With ALU_MUL_EN undefined: op 111 with 0x0003, 0x0004 -> alu_done at N+1, result 0x0000, Z=1, N=0.
